prefetch_queue: RTL

Parametrised instruction prefetch unit between the program-counter/branch logic and the decoder. It fetches sequential instruction bytes from the cache through a request/acknowledge handshake and buffers up to DEPTH of them in a circular queue. It delivers them to the decoder through a valid/ready port, with each byte tagged by its address. A flush, driven by a taken branch, discards the queue and restarts fetching at a new address.

---
 rtl/prefetch_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches sequential bytes from the cache and buffers DEPTH of them for the decoder.
// Optional feature: define PREFETCH_BYPASS_EN to forward an ack'd byte straight to the decoder when the queue is empty.
module prefetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        flush_addr,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {KILL, REQ, FULL} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q   [DEPTH];

  logic               queue_valid;
  logic               fetch_hit;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count_next;

  assign mem_addr    = fetch_pc;
  assign queue_valid = (count != '0);
  // A flush discards any ack arriving in the same cycle.
  assign fetch_hit   = (state == REQ) && mem_ack && !flush;
  assign pop         = queue_valid && out_ready && !flush;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass    = fetch_hit && (count == '0);
  assign out_valid = queue_valid || bypass;
  assign out_data  = bypass ? mem_data : data_q[head];
  assign out_pc    = bypass ? fetch_pc : pc_q[head];
  // A bypassed byte taken by the decoder never enters the queue.
  assign push      = fetch_hit && !(bypass && out_ready);
`else
  assign out_valid = queue_valid;
  assign out_data  = data_q[head];
  assign out_pc    = pc_q[head];
  assign push      = fetch_hit;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= KILL;
      mem_req  <= 1'b0;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      // NOTE: the storage is reset because out_data/out_pc must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (flush) begin
      state    <= KILL;
      mem_req  <= 1'b0;
      fetch_pc <= flush_addr;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        data_q[tail] <= mem_data;
        pc_q[tail]   <= fetch_pc;
        tail         <= tail + PTR_W'(1);
      end
      if (fetch_hit) fetch_pc <= fetch_pc + ADDR_W'(1);
      if (pop)       head     <= head + PTR_W'(1);
      count <= count_next;

      unique case (state)
        KILL: begin
          state   <= REQ;
          mem_req <= 1'b1;
        end
        REQ: begin
          if (count_next == CNT_W'(DEPTH)) begin
            state   <= FULL;
            mem_req <= 1'b0;
          end else begin
            mem_req <= 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        default: begin
          state   <= KILL;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
